// File: rtl/mk1_lsu_pkg.sv
// Shared definitions for the Mk1 load/store unit: op codes, FSM encoding, datapath width.
package mk1_lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] OP_LI  = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_WB    = 2'b10,
      ST_FAULT = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Counts cycles spent waiting for a memory ack; expire fires in the last allowed wait cycle.
module lsu_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Combinational so the FSM leaves REQ exactly TIMEOUT cycles after entering it.
   assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/load_store_ctrl.sv
// Mk1 load/store sequencer: accepts one LI/LW/SW op, runs the memory req/ack handshake
// and produces a single registered writeback / done / fault pulse per op.
module load_store_ctrl
   import mk1_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = mk1_lsu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [1:0]      op_code,
   input  logic [4:0]      op_rd,
   input  logic [XLEN-1:0] op_base,
   input  logic [XLEN-1:0] op_imm,
   input  logic [XLEN-1:0] op_wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            done,
   output logic            fault,
   output logic            busy
);

   lsu_state_e      state;
   logic [XLEN-1:0] eff_addr;
   logic            tmo_expire;

   assign eff_addr = op_base + op_imm;

   lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state != ST_REQ),
      .en     ((state == ST_REQ) && !mem_ack),
      .expire (tmo_expire)
   );

   // Outputs are registered alongside the state, so each pulse lines up with its state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_ready  <= 1'b1;
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_en     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         wb_en <= 1'b0;
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_valid && op_ready) begin
                  op_ready  <= 1'b0;
                  busy      <= 1'b1;
                  wb_rd     <= op_rd;
                  mem_addr  <= eff_addr;
                  mem_wdata <= op_wdata;
                  case (op_code)
                     OP_LI: begin
                        wb_data <= op_imm;
                        wb_en   <= (op_rd != 5'd0);
                        done    <= 1'b1;
                        state   <= ST_WB;
                     end
                     OP_LW, OP_SW: begin
                        mem_we <= (op_code == OP_SW);
                        if (eff_addr[1:0] != 2'b00) begin
                           fault <= 1'b1;
                           state <= ST_FAULT;
                        end else begin
                           mem_req <= 1'b1;
                           state   <= ST_REQ;
                        end
                     end
                     default: begin
                        fault <= 1'b1;
                        state <= ST_FAULT;
                     end
                  endcase
               end
            end
            ST_REQ: begin
               // An ack in the expiry cycle still completes the op.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  if (mem_we) begin
                     op_ready <= 1'b1;
                     busy     <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     wb_data <= mem_rdata;
                     wb_en   <= (wb_rd != 5'd0);
                     state   <= ST_WB;
                  end
               end else if (tmo_expire) begin
                  mem_req <= 1'b0;
                  fault   <= 1'b1;
                  state   <= ST_FAULT;
               end
            end
            default: begin
               op_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl: randomized and directed ops, memory responder, output monitor.
module tb_load_store_ctrl;

   localparam int TO = 16;
   localparam int XL = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [1:0]    op_code = '0;
   logic [4:0]    op_rd = '0;
   logic [XL-1:0] op_base = '0, op_imm = '0, op_wdata = '0;
   logic          mem_req, mem_we;
   logic [XL-1:0] mem_addr, mem_wdata;
   logic          mem_ack = 1'b0;
   logic [XL-1:0] mem_rdata = '0;
   logic          wb_en;
   logic [4:0]    wb_rd;
   logic [XL-1:0] wb_data;
   logic          done, fault, busy;

   load_store_ctrl #(.TIMEOUT(TO), .XLEN(XL)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_rd(op_rd),
      .op_base(op_base), .op_imm(op_imm), .op_wdata(op_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .done(done), .fault(fault), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      bit            wb;
      logic [4:0]    rd;
      logic [XL-1:0] data;
      bit            dn;
      bit            flt;
      bit            rdy;
   } exp_t;

   typedef struct {
      bit            we;
      logic [XL-1:0] addr;
      logic [XL-1:0] wdata;
      int            d;
      logic [XL-1:0] rdata;
   } mreq_t;

   exp_t  exp_q[$];
   mreq_t mq[$];
   int    tests = 0;
   int    fails = 0;
   bit    mon_en = 1'b0;

   task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: the completion each op must produce and the cycle it must appear in.
   task automatic issue(input logic [1:0] code, input logic [4:0] rd, input logic [XL-1:0] base,
                        input logic [XL-1:0] imm, input logic [XL-1:0] wdata, input int d,
                        input logic [XL-1:0] rdata);
      exp_t          e;
      mreq_t         m;
      logic [XL-1:0] ea;
      int            t;
      int            guard;
      guard = 0;
      @(negedge clk);
      while (op_ready !== 1'b1) begin
         guard++;
         if (guard > 200) begin
            chk("op_ready_wait", 0, 1);
            return;
         end
         @(negedge clk);
      end
      t  = cyc;
      ea = base + imm;
      e.at = t + 1; e.wb = 0; e.rd = rd; e.data = '0; e.dn = 0; e.flt = 0; e.rdy = 0;
      if (code == 2'b00) begin
         e.wb = (rd != 0); e.data = imm; e.dn = 1;
      end else if (code == 2'b11 || ea[1:0] != 2'b00) begin
         e.flt = 1;
      end else begin
         m.we = (code == 2'b10); m.addr = ea; m.wdata = wdata; m.d = d; m.rdata = rdata;
         mq.push_back(m);
         if (d >= TO) begin
            e.flt = 1; e.at = t + TO + 1;
         end else begin
            e.at = t + d + 2; e.dn = 1;
            if (code == 2'b01) begin
               e.wb = (rd != 0); e.data = rdata;
            end else begin
               e.rdy = 1;
            end
         end
      end
      exp_q.push_back(e);
      op_valid = 1'b1; op_code = code; op_rd = rd; op_base = base; op_imm = imm; op_wdata = wdata;
      @(posedge clk);
      #1 op_valid = 1'b0;
      op_code = $urandom; op_base = $urandom; op_imm = $urandom; op_wdata = $urandom;
   endtask

   task automatic drain;
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs;
      chk("rst_op_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
   endtask

   // Memory responder: checks each request against the model and acks after its chosen delay.
   initial begin
      mreq_t cur;
      bit    active;
      int    n;
      active = 0; n = 0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mon_en) begin
            active = 0;
         end else if (mem_req === 1'b1) begin
            if (!active) begin
               if (mq.size() == 0) begin
                  chk("mem_req_unexpected", mem_req, 0);
               end else begin
                  cur = mq.pop_front();
                  active = 1; n = 0;
               end
            end
            if (active) begin
               n++;
               chk("mem_we", mem_we, cur.we);
               chk("mem_addr", mem_addr, cur.addr);
               if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
               if (n == cur.d + 1) begin
                  mem_ack = 1'b1; mem_rdata = cur.rdata; active = 0;
               end
            end
         end else if (active) begin
            active = 0; mem_ack = 1'b1; mem_rdata = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
         end
      end
   end

   // Monitor: every completion pulse is matched against the head of the scoreboard.
   initial begin
      exp_t e;
      bit   chk_next;
      chk_next = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) begin
            chk_next = 0;
         end else begin
            if (chk_next) chk("op_ready_after", op_ready, 1);
            chk_next = 0;
            chk("busy", busy, !op_ready);
            if (wb_en || done || fault) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pulse", {wb_en, done, fault}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("cycle", cyc, e.at);
                  chk("wb_en", wb_en, e.wb);
                  chk("done", done, e.dn);
                  chk("fault", fault, e.flt);
                  chk("op_ready_during", op_ready, e.rdy);
                  if (e.wb) begin
                     chk("wb_rd", wb_rd, e.rd);
                     chk("wb_data", wb_data, e.data);
                  end
                  chk_next = !e.rdy;
               end
            end
         end
      end
   end

   initial begin
      logic [1:0]    c;
      logic [XL-1:0] b, im;
      int            d;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs();
      #1 rst_n = 1'b1;
      mon_en = 1'b1;

      issue(2'b00, 5'd3, 32'h0, 32'h12, 32'h0, 0, 32'h0);
      issue(2'b01, 5'd7, 32'h100, 32'h4, 32'h0, 0, 32'hDEADBEEF);
      issue(2'b10, 5'd0, 32'hFFFFFFFC, 32'h8, 32'hA5A5A5A5, 3, 32'h0);
      issue(2'b01, 5'd9, 32'h101, 32'h0, 32'h0, 0, 32'h0);
      issue(2'b11, 5'd9, 32'h100, 32'h0, 32'h0, 0, 32'h0);
      issue(2'b01, 5'd4, 32'h200, 32'h0, 32'h0, TO, 32'h11111111);
      issue(2'b01, 5'd5, 32'h300, 32'h0, 32'h0, TO - 1, 32'h22222222);
      issue(2'b00, 5'd0, 32'h0, 32'h55, 32'h0, 0, 32'h0);
      issue(2'b01, 5'd0, 32'h40, 32'h0, 32'h0, 1, 32'h33333333);
      drain();

      for (int i = 0; i < 80; i++) begin
         c  = 2'($urandom_range(0, 3));
         b  = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
         im = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 63), 2'b00} : $urandom;
         d  = ($urandom_range(0, 7) == 0) ? (TO - 1 + $urandom_range(0, 1)) : $urandom_range(0, 4);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(c, 5'($urandom), b, im, $urandom, d, $urandom);
      end
      drain();

      issue(2'b01, 5'd6, 32'h500, 32'h0, 32'h0, TO + 5, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("req_before_reset", mem_req, 1);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      mq.delete();
      @(negedge clk);
      chk_reset_outputs();
      issue(2'b00, 5'd12, 32'h0, 32'hCAFE0001, 32'h0, 0, 32'h0);
      drain();
      repeat (4) @(negedge clk);
      chk("mq_leftover", mq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d, expected completion before it", cyc);
      $fatal(1, "bench time limit reached");
   end

endmodule
